// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot select driver, index taken directly or from an up/down auto-scan with programmable dwell.
// Latency: exactly 1 clock from EN/Mode/Load/In to Out/Index/Valid/Wrap; no combinational input-to-output path.
// Backpressure: none; EN low blanks the select lines and freezes the index and dwell counter.
module scan_decoder #(
  parameter int IN_WIDTH = 2,
  parameter int DWELL    = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [1:0]                Mode,
  input  logic                      Load,
  input  logic [IN_WIDTH-1:0]       In,
  output logic [0:(2**IN_WIDTH)-1]  Out,
  output logic [IN_WIDTH-1:0]       Index,
  output logic                      Valid,
  output logic                      Wrap
);

  localparam int OUT_WIDTH = 2**IN_WIDTH;
  // A dwell of one needs no real counter, but keep a 1-bit register so the datapath shape is uniform.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]       CNT_MAX = CW'(DWELL - 1);
  localparam logic [IN_WIDTH-1:0] IDX_MAX = '1;
  localparam logic [IN_WIDTH-1:0] IDX_MIN = '0;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       nxt_cnt;
  logic [IN_WIDTH-1:0] nxt_index;
  logic                nxt_wrap;

  // Select line i is driven when the index equals i; Out is declared ascending so bit 0 is the leftmost.
  function automatic logic [0:OUT_WIDTH-1] onehot(input logic [IN_WIDTH-1:0] idx);
    logic [0:OUT_WIDTH-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next index/dwell/wrap for an enabled edge; Load beats a dwell expiry so a reload never wraps.
  always_comb begin
    nxt_index = Index;
    nxt_cnt   = cnt;
    nxt_wrap  = 1'b0;
    case (mode_e'(Mode))
      MODE_DIRECT: begin
        nxt_index = In;
        nxt_cnt   = '0;
      end
      MODE_UP, MODE_DOWN: begin
        if (Load) begin
          nxt_index = In;
          nxt_cnt   = '0;
        end else if (cnt == CNT_MAX) begin
          nxt_cnt = '0;
          if (Mode == MODE_UP) begin
            nxt_index = Index + 1'b1;
            nxt_wrap  = (Index == IDX_MAX);
          end else begin
            nxt_index = Index - 1'b1;
            nxt_wrap  = (Index == IDX_MIN);
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: begin
        nxt_index = Index;
        nxt_cnt   = cnt;
      end
    endcase
  end

  // All outputs are registered so the select lines never glitch; EN low blanks them but keeps scan position.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Out   <= '0;
      Index <= '0;
      Valid <= 1'b0;
      Wrap  <= 1'b0;
      cnt   <= '0;
    end else if (!EN) begin
      Out   <= '0;
      Valid <= 1'b0;
      Wrap  <= 1'b0;
    end else begin
      Index <= nxt_index;
      cnt   <= nxt_cnt;
      Out   <= onehot(nxt_index);
      Valid <= 1'b1;
      Wrap  <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: three decoders (dwell 1, 3, 4) share stimulus and are checked against a remaining-dwell model.
// Latency: every expectation applies to the outputs sampled 1 ns after the edge that consumed the inputs.
// Backpressure: not applicable; inputs are driven away from the rising edge.
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [1:0] din;

  logic [0:3] out_a, out_b, out_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       vld_a, vld_b, vld_c;
  logic       wrap_a, wrap_b, wrap_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index shown, cycles of dwell left for it, and the last Valid/Wrap.
  int dw      [3] = '{1, 3, 4};
  int m_idx   [3];
  int m_left  [3];
  bit m_valid [3];
  bit m_wrap  [3];

  scan_decoder #(.IN_WIDTH(2), .DWELL(1)) u_d1 (
    .CLK(clk), .RST(rst_n), .EN(en), .Mode(mode), .Load(load), .In(din),
    .Out(out_a), .Index(idx_a), .Valid(vld_a), .Wrap(wrap_a));
  scan_decoder #(.IN_WIDTH(2), .DWELL(3)) u_d3 (
    .CLK(clk), .RST(rst_n), .EN(en), .Mode(mode), .Load(load), .In(din),
    .Out(out_b), .Index(idx_b), .Valid(vld_b), .Wrap(wrap_b));
  scan_decoder #(.IN_WIDTH(2), .DWELL(4)) u_d4 (
    .CLK(clk), .RST(rst_n), .EN(en), .Mode(mode), .Load(load), .In(din),
    .Out(out_c), .Index(idx_c), .Valid(vld_c), .Wrap(wrap_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k]   = 0;
      m_left[k]  = dw[k];
      m_valid[k] = 1'b0;
      m_wrap[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input int m, input bit l, input int i);
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 1'b0;
      if (!e) begin
        m_valid[k] = 1'b0;
      end else begin
        m_valid[k] = 1'b1;
        if (m == 0 || ((m == 1 || m == 2) && l)) begin
          m_idx[k]  = i;
          m_left[k] = dw[k];
        end else if (m == 1 || m == 2) begin
          if (m_left[k] == 1) begin
            m_left[k] = dw[k];
            if (m == 1) begin
              m_wrap[k] = (m_idx[k] == 3);
              m_idx[k]  = (m_idx[k] + 1) % 4;
            end else begin
              m_wrap[k] = (m_idx[k] == 0);
              m_idx[k]  = (m_idx[k] + 3) % 4;
            end
          end else begin
            m_left[k] = m_left[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input string tag, input int k, input logic [0:3] o,
                          input logic [1:0] ix, input logic v, input logic w);
    logic [3:0] eo;
    eo = m_valid[k] ? (4'b1000 >> m_idx[k]) : 4'b0000;
    check({tag, "_state"}, {24'd0, o, ix, v, w}, {24'd0, eo, 2'(m_idx[k]), m_valid[k], m_wrap[k]});
    check({tag, "_inv"}, v ? 32'($onehot(o) && o[ix]) : 32'(o == 4'b0000), 32'd1);
  endtask

  task automatic compare_all();
    cmp_inst("d1", 0, out_a, idx_a, vld_a, wrap_a);
    cmp_inst("d3", 1, out_b, idx_b, vld_b, wrap_b);
    cmp_inst("d4", 2, out_c, idx_c, vld_c, wrap_c);
  endtask

  // Drive inputs, let one rising edge consume them, then compare 1 ns later.
  task automatic step(input bit e, input int m, input bit l, input int i);
    en   = e;
    mode = 2'(m);
    load = l;
    din  = 2'(i);
    @(posedge clk);
    model_step(e, m, l, i);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_dir [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] exp_up  [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
  logic [3:0] exp_dn  [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] exp_en  [3] = '{4'b1000, 4'b1000, 4'b0100};
  logic [1:0] exp_ld  [4] = '{2'd1, 2'd1, 2'd1, 2'd2};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    load  = 1'b0;
    din   = 2'd0;
    #2;
    model_reset();
    compare_all();
    #8;
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    step(0, 0, 1, 3);

    // Direct decode of every index.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, i);
      check("direct_out", 32'(out_a), 32'(exp_dir[i]));
      check("direct_vld", 32'(vld_a), 32'd1);
    end

    // Scan up, dwell 3, loaded at index 2, through the wrap.
    step(1, 1, 1, 2);
    check("up_out", 32'(out_b), 32'(exp_up[0]));
    for (int k = 1; k < 8; k++) begin
      step(1, 1, 0, 0);
      check("up_out", 32'(out_b), 32'(exp_up[k]));
      check("up_wrap", 32'(wrap_b), 32'(k == 6));
    end

    // Scan down, dwell 1, from index 1 through the wrap to 3.
    step(1, 2, 1, 1);
    check("dn_out", 32'(out_a), 32'(exp_dn[0]));
    for (int k = 1; k < 4; k++) begin
      step(1, 2, 0, 0);
      check("dn_out", 32'(out_a), 32'(exp_dn[k]));
      check("dn_wrap", 32'(wrap_a), 32'(k == 2));
    end

    // EN dropped after two dwell cycles at dwell 4; remaining dwell resumes afterwards.
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("en_off_out", 32'(out_c), 32'd0);
    check("en_off_vld", 32'(vld_c), 32'd0);
    step(0, 2, 1, 3);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      check("en_resume", 32'(out_c), 32'(exp_en[k]));
    end

    // Load coinciding with dwell expiry at index 3 (dwell 1 expires every edge).
    step(1, 1, 1, 3);
    step(1, 1, 1, 1);
    check("ldexp_idx", 32'(idx_a), 32'd1);
    check("ldexp_wrap", 32'(wrap_a), 32'd0);

    // Same at dwell 3, then confirm the loaded index gets a fresh full dwell.
    step(1, 1, 1, 3);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    check("ldexp3_idx", 32'(idx_b), 32'(exp_ld[0]));
    check("ldexp3_wrap", 32'(wrap_b), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step(1, 1, 0, 0);
      check("ldexp3_idx", 32'(idx_b), 32'(exp_ld[k]));
    end

    // Mid-scan asynchronous reset, then release with EN low.
    step(1, 1, 0, 0);
    async_reset();
    step(0, 1, 0, 0);
    step(0, 2, 0, 0);

    // Randomised traffic biased toward scanning, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      int m;
      r = $urandom_range(0, 9);
      m = (r == 0) ? 0 : (r == 1) ? 3 : (r < 6) ? 1 : 2;
      step($urandom_range(0, 9) != 0, m, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered one-hot decoder with an auto-scan sequencer. It drives one-hot select lines, one enable per ALU functional unit or operand bank, from the ALU control path. Select lines come from either a directly supplied index or an internal up/down scan counter with programmable dwell. All outputs are registered, so downstream select lines are glitch-free.

## Interface
- IN_WIDTH, 2: index width; OUT_WIDTH = 2**IN_WIDTH is a derived localparam, not overridable.
- DWELL, 1: cycles each index is held in scan modes; legal range ≥1, up to 2**16.
- CLK  input  1  rising-edge clock.
- RST  input  1  reset, asynchronous, active-low.
- EN  input  1  block enable; low clears select lines.
- Mode  input  2  00 direct, 01 scan up, 10 scan down, 11 hold.
- Load  input  1  scan modes only: load In as current index.
- In  input  IN_WIDTH  direct index / scan start index.
- Out  output  [0:OUT_WIDTH-1]  one-hot select; Out[i] high ⇔ Index == i.
- Index  output  IN_WIDTH  current registered index.
- Valid  output  1  high when Out is one-hot (non-zero).
- Wrap  output  1  one-cycle pulse on scan wrap-around.

## Operation
- Internal state: Index register, dwell counter cnt (width clog2(DWELL), min 1 bit), plus output registers.
- Reset (RST low, async): Out=0, Index=0, Valid=0, Wrap=0, cnt=0. Outputs stay at these values until the first rising edge with RST high.
- Priority each edge: EN low > Mode decode > Load > dwell advance.
- EN=0: Out←0, Valid←0, Wrap←0; Index and cnt hold. Mode, Load and In are ignored.
- Mode 00 (direct): Index←In, Out←onehot(In), Valid←1, cnt←0, Wrap←0. Load is ignored.
- Mode 01 (scan up):
  - Load=1: Index←In, cnt←0, Wrap←0.
  - Else if cnt==DWELL-1: cnt←0, Index←Index+1 mod OUT_WIDTH. Wrap←1 iff old Index == OUT_WIDTH-1.
  - Else cnt←cnt+1, Index holds, Wrap←0.
- Mode 10 (scan down): same rules as scan up, with Index←Index-1 mod OUT_WIDTH; Wrap←1 iff old Index == 0.
- Mode 11 (hold): Index and cnt hold; Out←onehot(Index), Valid←1, Wrap←0. Load is ignored.
- In any EN=1 mode: Out←onehot(next Index), Valid←1.
- Invariant: Valid==1 ⇒ Out == onehot(Index), with exactly one bit set; Valid==0 ⇒ Out==0.
- Switching between modes 01 and 10 preserves cnt and Index. The direction reverses from the current index without skipping it.
- Leaving mode 00 for a scan mode starts with cnt=0, because direct mode keeps cnt at 0.
- DWELL=1: the index advances every cycle, and cnt is constant 0.

## Timing
- Latency from In/Mode/EN/Load to Out/Index/Valid/Wrap is exactly 1 clock; there is no combinational input→output path.
- Wrap is asserted in the same cycle that Out first shows the wrapped index, and lasts 1 cycle.
- Scan period: each index is visible for DWELL cycles. A full cycle takes OUT_WIDTH*DWELL cycles between Wrap pulses.
- Load during a scan restarts the dwell: the loaded index is shown for DWELL cycles from the cycle after Load.
- Load on the same edge as a dwell expiry: Load wins, there is no advance, and Wrap=0.
- EN deassert mid-dwell freezes cnt. On re-enable the scan resumes with the remaining dwell, and Out reappears 1 cycle after EN rises.
- Async reset mid-scan clears all state immediately; it does not wait for CLK.
- Reset release is synchronised externally; the block only requires RST to deassert away from the CLK edge.

## Test plan
- Reset: drive RST low mid-scan → Out=0, Index=0, Valid=0 and Wrap=0 before the next CLK edge. After release with EN=0 the outputs remain 0.
- Direct decode, IN_WIDTH=2: In=0,1,2,3 on successive cycles → Out=1000,0100,0010,0001 one cycle later, with Valid=1 throughout.
- Scan up, DWELL=3, Load In=2: Out=0010 for 3 cycles, then 0001 for 3 cycles. Out then shows 1000 with Wrap=1 for exactly that first cycle.
- Scan down, DWELL=1, from Index=1: Out sequence is 0100, 1000, 0001 (Wrap=1 with 0001), then 0010.
- EN toggle, DWELL=4: EN=0 after 2 dwell cycles → Out=0 and Valid=0. After EN=1 the same index shows for the remaining 2 cycles before advancing.
- Simultaneous Load and dwell expiry at Index=3 in scan up: Load In=1 → Index=1, Wrap=0, and a fresh dwell begins.
- Randomised check: assert the invariant Valid ⇒ $onehot(Out) && Out[Index].
